fp16_accumulator: RTL and testbench

Sequential FP16 accumulator that sits directly downstream of the systolic-array half-precision multiplier. It consumes a stream of products over a valid/ready handshake and adds each one into a 16-bit FP16 running sum. When the beat flagged `in_last` has been added, it presents the sum and the beat count on a held output handshake, then clears itself for the next dot product. The arithmetic uses the multiplier's conventions: 1-5-10 format, bias 15, truncation, and no inf/NaN handling.

---
 rtl/fp16_accumulator_if.sv | 29 ++
 rtl/fp16_accumulator.sv | 180 ++++++++++++++++++
 tb/tb_fp16_accumulator.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_accumulator_if.sv
// fp16_accumulator_if
//   Handshake bundle between the FP16 product stream, the accumulator and
//   the result consumer.
//   Product side : in_valid, in_data[15:0], in_last, in_ready
//   Result side  : out_valid, out_data[15:0], out_count[CNT_W-1:0], out_ready
//   slave modport  : accumulator view
//   master modport : producer/consumer view (testbench or upstream logic)
interface fp16_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp16_accumulator.sv
// fp16_accumulator
//   Sequential FP16 (1-5-10, bias 15) running-sum accumulator. Each accepted
//   product is added into acc over ALIGN/ADD/NORM (truncating, denormals
//   flushed, no inf/NaN). After the beat flagged in_last the sum and beat
//   count are held on the output handshake, then cleared once consumed.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - fp16_accumulator_if.slave (product in, result out)
//   Build option:
//     FP16_ACC_SAT_EN - when defined, exponent overflow saturates to
//                       +/-65504; otherwise the exponent wraps (low 5 bits).
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | waiting for a product (in_ready high)
//   ALIGN | zero test, pick larger operand, shift smaller
//   ADD   | 12-bit mantissa add/subtract
//   NORM  | normalise, write acc
//   DONE  | result held on out_valid until out_ready
module fp16_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fp16_accumulator_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} stateT;

  stateT            state, stateNext;
  logic [15:0]      acc;
  logic [CNT_W-1:0] count;
  logic [15:0]      xReg;
  logic             lastReg;

  // ALIGN -> ADD/NORM pipeline registers
  logic             bypass;
  logic [15:0]      bypassVal;
  logic             signL;
  logic [4:0]       expL;
  logic [10:0]      mantL;
  logic [10:0]      mantS;
  logic             subtract;
  logic [11:0]      sumReg;

  // ALIGN combinational terms
  logic        xZero, accZero, accIsL;
  logic [15:0] lOp, sOp;
  logic [4:0]  shiftD;
  logic [10:0] alignedS;

  always_comb begin
    xZero    = (xReg[14:10] == 5'd0);
    accZero  = (acc[14:10] == 5'd0);
    // Tie on magnitude keeps acc as the larger operand.
    accIsL   = (acc[14:0] >= xReg[14:0]);
    lOp      = accIsL ? acc : xReg;
    sOp      = accIsL ? xReg : acc;
    shiftD   = lOp[14:10] - sOp[14:10];
    alignedS = (shiftD >= 5'd11) ? 11'd0 : ({1'b1, sOp[9:0]} >> shiftD);
  end

  // NORM combinational terms
  logic [3:0]         lz;
  logic [10:0]        shifted;
  logic [9:0]         mantN;
  logic signed [6:0]  expCalc;
  logic [15:0]        normResult;

  always_comb begin
    lz = 4'd0;
    // Highest set bit wins, so the last hit gives the leading-zero count.
    for (int i = 0; i <= 10; i++) begin
      if (sumReg[i]) lz = 4'(10 - i);
    end
    shifted = sumReg[10:0] << lz;
    if (sumReg[11]) begin
      mantN   = sumReg[10:1];
      expCalc = $signed({2'b00, expL}) + 7'sd1;
    end else begin
      mantN   = shifted[9:0];
      expCalc = $signed({2'b00, expL}) - $signed({3'b000, lz});
    end

    if (bypass) begin
      normResult = bypassVal;
    end else if (sumReg == 12'd0 || expCalc <= 7'sd0) begin
      normResult = 16'h0000;
    end else if (expCalc >= 7'sd31) begin
`ifdef FP16_ACC_SAT_EN
      normResult = {signL, 5'h1E, 10'h3FF};
`else
      normResult = {signL, expCalc[4:0], mantN};
`endif
    end else begin
      normResult = {signL, expCalc[4:0], mantN};
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // FSM: next state and handshake outputs
  always_comb begin
    stateNext     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) stateNext = ALIGN;
      end
      ALIGN: stateNext = ADD;
      ADD:   stateNext = NORM;
      NORM:  stateNext = lastReg ? DONE : IDLE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.out_data  = acc;
  assign bus.out_count = count;

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= 16'h0000;
      count     <= '0;
      xReg      <= 16'h0000;
      lastReg   <= 1'b0;
      bypass    <= 1'b0;
      bypassVal <= 16'h0000;
      signL     <= 1'b0;
      expL      <= 5'd0;
      mantL     <= 11'd0;
      mantS     <= 11'd0;
      subtract  <= 1'b0;
      sumReg    <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xReg    <= bus.in_data;
            lastReg <= bus.in_last;
            if (~&count) count <= count + 1'b1;
          end
        end
        ALIGN: begin
          bypass    <= xZero | accZero;
          bypassVal <= xZero ? acc : xReg;
          signL     <= lOp[15];
          expL      <= lOp[14:10];
          mantL     <= {1'b1, lOp[9:0]};
          mantS     <= alignedS;
          subtract  <= lOp[15] ^ sOp[15];
        end
        ADD: begin
          sumReg <= subtract ? ({1'b0, mantL} - {1'b0, mantS})
                             : ({1'b0, mantL} + {1'b0, mantS});
        end
        NORM: acc <= normResult;
        DONE: begin
          if (bus.out_ready) begin
            acc   <= 16'h0000;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_accumulator.sv
module tb_fp16_accumulator;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fp16_accumulator_if #(.CNT_W(CNT_W)) bus ();

  fp16_accumulator #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // FP16 addition from the arithmetic rules, using plain integers.
  function automatic logic [15:0] fpAdd(input logic [15:0] a, input logic [15:0] x);
    int eA, eX, eL, eS, mL, mS, sum, e;
    logic sL, sS, aBig;
    eA = int'(a[14:10]);
    eX = int'(x[14:10]);
    if (eX == 0) return a;
    if (eA == 0) return x;
    aBig = (int'(a[14:0]) >= int'(x[14:0]));
    sL = aBig ? a[15] : x[15];
    sS = aBig ? x[15] : a[15];
    eL = aBig ? eA : eX;
    eS = aBig ? eX : eA;
    mL = 1024 + (aBig ? int'(a[9:0]) : int'(x[9:0]));
    mS = 1024 + (aBig ? int'(x[9:0]) : int'(a[9:0]));
    mS = mS >> (eL - eS);
    sum = (sL == sS) ? mL + mS : mL - mS;
    if (sum == 0) return 16'h0000;
    e = eL;
    if (sum >= 2048) begin
      sum = sum / 2;
      e = e + 1;
    end else begin
      while (sum < 1024) begin
        sum = sum * 2;
        e = e - 1;
      end
    end
    if (e <= 0) return 16'h0000;
`ifdef FP16_ACC_SAT_EN
    if (e >= 31) return {sL, 5'h1E, 10'h3FF};
`endif
    return {sL, 5'(e % 32), 10'(sum % 1024)};
  endfunction

  // Cycle model: phase 0 idle, 1..3 the three working cycles after accept.
  int          mPhase = 0;
  logic        mDone = 1'b0;
  logic [15:0] mAcc = 16'h0000;
  int          mCnt = 0;
  logic [15:0] mX = 16'h0000;
  logic        mLast = 1'b0;
  logic        modelOn = 1'b0;

  always @(negedge clk) begin
    if (modelOn) begin
      chk("in_ready", 32'(bus.in_ready), 32'(mPhase == 0 && !mDone));
      chk("out_valid", 32'(bus.out_valid), 32'(mDone));
      if (mDone) begin
        chk("out_data", 32'(bus.out_data), 32'(mAcc));
        chk("out_count", 32'(bus.out_count), 32'(mCnt));
      end
    end
    if (rst) begin
      mPhase = 0; mDone = 1'b0; mAcc = 16'h0000; mCnt = 0; modelOn = 1'b1;
    end else if (mDone) begin
      if (bus.out_ready) begin
        mDone = 1'b0; mAcc = 16'h0000; mCnt = 0;
      end
    end else if (mPhase == 0) begin
      if (bus.in_valid) begin
        mX = bus.in_data;
        mLast = bus.in_last;
        if (mCnt < CNT_MAX) mCnt++;
        mPhase = 1;
      end
    end else if (mPhase < 3) begin
      mPhase++;
    end else begin
      mAcc = fpAdd(mAcc, mX);
      mPhase = 0;
      mDone = mLast;
    end
  end

  task automatic sendBeat(input logic [15:0] data, input logic last, input logic randOr);
    logic accepted;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data = data;
    bus.in_last = last;
    accepted = 1'b0;
    for (int i = 0; i < 400 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) accepted = 1'b1;
      @(posedge clk); #1;
      if (randOr) bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'($urandom_range(0, 1));
    bus.in_data = 16'($urandom);
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic expectResult(input string name, input logic [15:0] expD, input int expC,
                              output int lat);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) lat = i;
    end
    if (lat == 0) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_data"}, 32'(bus.out_data), 32'(expD));
      chk({name, "_count"}, 32'(bus.out_count), 32'(expC));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    logic [15:0] held;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0000;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;

    // Hand-computed pins on the model itself.
    chk("pin_add", 32'(fpAdd(16'h3C00, 16'h4000)), 32'h4200);
    chk("pin_sub", 32'(fpAdd(16'h4000, 16'hBC00)), 32'h3C00);
    chk("pin_cancel", 32'(fpAdd(16'h3C00, 16'hBC00)), 32'h0000);
    chk("pin_zero", 32'(fpAdd(16'h0000, 16'h3800)), 32'h3800);
`ifdef FP16_ACC_SAT_EN
    chk("pin_ovf", 32'(fpAdd(16'h7BFF, 16'h7BFF)), 32'h7BFF);
`else
    chk("pin_ovf", 32'(fpAdd(16'h7BFF, 16'h7BFF)), 32'h7FFF);
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_count", 32'(bus.out_count), 32'h0);

    sendBeat(16'h3C00, 1'b1, 1'b0);
    expectResult("single", 16'h3C00, 1, lat);
    chk("single_latency", 32'(lat), 32'd4);

    sendBeat(16'h3C00, 1'b0, 1'b0);
    sendBeat(16'h4000, 1'b1, 1'b0);
    expectResult("two_beat", 16'h4200, 2, lat);

    sendBeat(16'h4000, 1'b0, 1'b0);
    sendBeat(16'hBC00, 1'b1, 1'b0);
    expectResult("mixed_norm", 16'h3C00, 2, lat);

    sendBeat(16'h3C00, 1'b0, 1'b0);
    sendBeat(16'hBC00, 1'b1, 1'b0);
    expectResult("cancel", 16'h0000, 2, lat);

    sendBeat(16'h0001, 1'b0, 1'b0);
    sendBeat(16'h3800, 1'b1, 1'b0);
    expectResult("zero_flush", 16'h3800, 2, lat);

    sendBeat(16'h7BFF, 1'b0, 1'b0);
    sendBeat(16'h7BFF, 1'b1, 1'b0);
`ifdef FP16_ACC_SAT_EN
    expectResult("overflow", 16'h7BFF, 2, lat);
`else
    expectResult("overflow", 16'h7FFF, 2, lat);
`endif

    // Backpressure
    @(posedge clk); #1 bus.out_ready = 1'b0;
    sendBeat(16'h4400, 1'b1, 1'b0);
    expectResult("bp", 16'h4400, 1, lat);
    held = bus.out_data;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      chk("bp_data_hold", 32'(bus.out_data), 32'(held));
      chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    sendBeat(16'h3C00, 1'b1, 1'b0);
    expectResult("bp_acc_cleared", 16'h3C00, 1, lat);

    // Reset while ADD is in flight
    sendBeat(16'h3C00, 1'b0, 1'b0);
    sendBeat(16'h4000, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'h0);
    chk("midrst_out_count", 32'(bus.out_count), 32'h0);
    sendBeat(16'h4000, 1'b1, 1'b0);
    expectResult("after_rst", 16'h4000, 1, lat);

    // Count saturation
    for (int i = 0; i < 259; i++) sendBeat(16'h0000, 1'b0, 1'b0);
    sendBeat(16'h3C00, 1'b1, 1'b0);
    expectResult("count_sat", 16'h3C00, CNT_MAX, lat);

    // Randomized dot products checked by the cycle model
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        logic [15:0] d;
        if ($urandom_range(0, 3) == 0) d = 16'($urandom);
        else d = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
        repeat ($urandom_range(0, 2)) @(posedge clk);
        sendBeat(d, 1'(b == len - 1), 1'b1);
      end
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
